mdio_ctrl: RTL and testbench

The `mdio_controller` block is an IEEE 802.3 Clause 22 MDIO management master that serialises one read or write frame per `start` request toward an external PHY. It generates the MDC clock and drives MDIO through a tri-state pair (`mdio_out`/`mdio_oe`). For reads, it samples `mdio_in`, and it returns the 16-bit register value on `read_data`. It sits between the host/register-access logic and the chip-level MDIO pad.

---
 rtl/mdio_ctrl.sv | 114 +++++++++++
 tb/tb_mdio_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_ctrl.sv
// Clause 22 MDIO management master: one 64-bit read or write frame per accepted start,
// one MDIO bit per clk cycle, MDC derived from busy and the inverted system clock.
module mdio_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        operation,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] write_data,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        mdc,
  output logic [15:0] read_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StHdr, StTa, StData} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rdata_q, rdata_d;
  logic        accept;
  logic        last_bit;
  logic [63:0] frame;
  logic        frame_bit;

  assign last_bit = (state_q == StData) && (cnt_q == 6'd63);
  // The completing edge may also accept the next request, giving a zero idle gap.
  assign accept   = start && ((state_q == StIdle) || last_bit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: ;
      StHdr: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd45) state_d = StTa;
      end
      StTa: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd47) state_d = StData;
      end
      StData: begin
        if (op_q) shift_d = {shift_q[14:0], mdio_in};
        if (cnt_q == 6'd63) begin
          if (op_q) rdata_d = {shift_q[14:0], mdio_in};
          state_d = StIdle;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StHdr;
      cnt_d   = 6'd0;
      op_d    = operation;
      phy_d   = phy_addr;
      reg_d   = reg_addr;
      wdata_d = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      op_q    <= 1'b0;
      phy_q   <= 5'd0;
      reg_q   <= 5'd0;
      wdata_q <= 16'd0;
      shift_q <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
    end
  end

  // Bit k of the frame lives at frame[63-k].
  assign frame     = {32'hFFFF_FFFF, 2'b01, (op_q ? 2'b10 : 2'b01), phy_q, reg_q, 2'b10,
                      wdata_q};
  assign frame_bit = frame[6'd63 - cnt_q];

  assign busy      = (state_q != StIdle);
  assign mdio_oe   = busy && !(op_q && (cnt_q >= 6'd46));
  assign mdio_out  = mdio_oe && frame_bit;
  assign mdc       = busy && !clk;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_mdio_ctrl.sv
// Bench for mdio_ctrl: frame-level model compared every cycle, a PHY responder on mdio_in,
// and literal checks on captured serial streams.
module tb_mdio_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        operation;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] write_data;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdc;
  logic [15:0] read_data;
  logic        busy;

  mdio_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .operation  (operation),
    .phy_addr   (phy_addr),
    .reg_addr   (reg_addr),
    .write_data (write_data),
    .mdio_in    (mdio_in),
    .mdio_out   (mdio_out),
    .mdio_oe    (mdio_oe),
    .mdc        (mdc),
    .read_data  (read_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: serial stream built from field layout, position counter, captured read bits.
  logic        m_busy = 1'b0;
  int          m_k = 0;
  logic        m_op = 1'b0;
  logic [63:0] m_frame = '0;
  logic [15:0] m_cap = '0;
  logic [15:0] m_rd = '0;
  logic        m_accept;
  logic        chk_en = 1'b0;
  logic [15:0] phy_val = 16'h0000;

  function automatic logic [63:0] build_frame(input logic op, input logic [4:0] pa,
                                              input logic [4:0] ra, input logic [15:0] wd);
    logic [63:0] f;
    for (int k = 0; k < 32; k++) f[63-k] = 1'b1;
    f[63-32] = 1'b0;
    f[63-33] = 1'b1;
    f[63-34] = op;
    f[63-35] = !op;
    for (int i = 0; i < 5; i++) f[63-(36+i)] = pa[4-i];
    for (int i = 0; i < 5; i++) f[63-(41+i)] = ra[4-i];
    f[63-46] = 1'b1;
    f[63-47] = 1'b0;
    for (int i = 0; i < 16; i++) f[63-(48+i)] = wd[15-i];
    return f;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_rd   = 16'h0000;
    end else begin
      m_accept = start && (!m_busy || m_k == 63);
      if (m_busy) begin
        if (m_op && m_k >= 48) m_cap[15-(m_k-48)] = mdio_in;
        if (m_k == 63) begin
          m_busy = 1'b0;
          if (m_op) m_rd = m_cap;
        end else begin
          m_k = m_k + 1;
        end
      end
      if (m_accept) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_op    = operation;
        m_frame = build_frame(operation, phy_addr, reg_addr, write_data);
      end
    end
  end

  logic [63:0] obs_out = '0;
  logic [63:0] obs_oe = '0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_oe;
      exp_oe = m_busy && !(m_op && m_k >= 46);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("mdio_oe", 64'(mdio_oe), 64'(exp_oe));
      if (exp_oe) chk("mdio_out", 64'(mdio_out), 64'(m_frame[63-m_k]));
      else if (!m_busy) chk("mdio_out_idle", 64'(mdio_out), 64'd0);
      chk("mdc", 64'(mdc), 64'(m_busy));
      chk("read_data", 64'(read_data), 64'(m_rd));
      if (busy) begin
        obs_out[63-m_k] = mdio_out;
        obs_oe[63-m_k]  = mdio_oe;
        busy_cycles++;
      end
    end
    // PHY drives the data bit for the cycle it will be sampled at.
    mdio_in = (m_busy && m_op && m_k >= 48) ? phy_val[15-(m_k-48)] : 1'b0;
  end

  task automatic issue(input logic op, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd);
    @(negedge clk);
    start = 1'b1;
    operation = op;
    phy_addr = pa;
    reg_addr = ra;
    write_data = wd;
    @(negedge clk);
    start = 1'b0;
    operation = ~op;
    phy_addr = 5'h1F;
    reg_addr = 5'h1F;
    write_data = 16'hFFFF;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_bit(input int k, input string name);
    int n;
    n = 0;
    while (m_k != k && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (m_k != k) chk({name, "_timeout"}, 64'(m_k), 64'(k));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    operation = 1'b0;
    phy_addr = '0;
    reg_addr = '0;
    write_data = '0;
    mdio_in = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_oe", 64'(mdio_oe), 64'd0);
    chk("rst_out", 64'(mdio_out), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_rdata", 64'(read_data), 64'd0);

    // Write frame
    busy_cycles = 0;
    issue(1'b0, 5'h01, 5'h02, 16'hABCD);
    wait_idle("wr");
    chk("wr_stream", obs_out, {32'hFFFF_FFFF, 4'b0101, 5'b00001, 5'b00010, 2'b10, 16'hABCD});
    chk("wr_oe", obs_oe, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wr_busy_len", 64'(busy_cycles), 64'd64);
    chk("wr_rdata", 64'(read_data), 64'd0);

    // Read frame
    phy_val = 16'h1234;
    busy_cycles = 0;
    issue(1'b1, 5'h03, 5'h04, 16'h5555);
    wait_idle("rd");
    chk("rd_header", 64'(obs_out[63:18]), 64'({32'hFFFF_FFFF, 4'b0110, 5'b00011, 5'b00100}));
    chk("rd_oe", obs_oe, 64'hFFFF_FFFF_FFFC_0000);
    chk("rd_busy_len", 64'(busy_cycles), 64'd64);
    chk("rd_data", 64'(read_data), 64'h1234);

    // Start while busy is ignored
    busy_cycles = 0;
    issue(1'b0, 5'h05, 5'h06, 16'h0F0F);
    wait_bit(20, "rej");
    start = 1'b1;
    operation = 1'b1;
    phy_addr = 5'h0A;
    reg_addr = 5'h0B;
    write_data = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    wait_idle("rej");
    chk("rej_stream", obs_out, {32'hFFFF_FFFF, 4'b0101, 5'b00101, 5'b00110, 2'b10, 16'h0F0F});
    chk("rej_busy_len", 64'(busy_cycles), 64'd64);
    repeat (3) @(negedge clk);
    chk("rej_no_second", 64'(busy), 64'd0);
    chk("rej_rdata", 64'(read_data), 64'h1234);

    // Reset during a read
    phy_val = 16'hFFFF;
    issue(1'b1, 5'h03, 5'h04, 16'h0000);
    wait_bit(50, "mid");
    reset = 1'b0;
    @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_oe", 64'(mdio_oe), 64'd0);
    chk("mid_rdata", 64'(read_data), 64'd0);
    reset = 1'b1;
    busy_cycles = 0;
    issue(1'b0, 5'h1B, 5'h11, 16'h8001);
    wait_idle("post");
    chk("post_stream", obs_out, {32'hFFFF_FFFF, 4'b0101, 5'b11011, 5'b10001, 2'b10, 16'h8001});
    chk("post_busy_len", 64'(busy_cycles), 64'd64);

    // Back-to-back write then read with zero gap
    phy_val = 16'hBEEF;
    busy_cycles = 0;
    issue(1'b0, 5'h07, 5'h08, 16'h00FF);
    wait_bit(63, "b2b");
    start = 1'b1;
    operation = 1'b1;
    phy_addr = 5'h09;
    reg_addr = 5'h0C;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_held", 64'(busy), 64'd1);
    chk("b2b_first_bit", 64'(mdio_out), 64'd1);
    wait_idle("b2b");
    chk("b2b_busy_len", 64'(busy_cycles), 64'd128);
    chk("b2b_header", 64'(obs_out[63:18]), 64'({32'hFFFF_FFFF, 4'b0110, 5'b01001, 5'b01100}));
    chk("b2b_rdata", 64'(read_data), 64'hBEEF);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
